mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the core's data-memory port, downstream of the single-cycle core.
- Consumes the core's mem_write, mem_addr and mem_wdata. Returns status on a combinational read-data path that the top-level read mux selects with sel.
- Buffers bytes in a small FIFO and serialises them as 8N1 frames on tx, LSB first.
- Lets software write bytes at core speed without polling per bit.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit. Must be ≥2.
- FIFO_DEPTH, 8: TX FIFO entries. Power of two, ≥2.
- BASE_ADDR, 32'h0000_0400: 8-byte-aligned base of the register window.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- mem_write  in  1  core store strobe
- mem_addr  in  32  core data address
- mem_wdata  in  32  core store data
- sel  out  1  combinational: mem_addr[31:3] == BASE_ADDR[31:3]
- rdata  out  32  combinational read data, valid when sel
- tx  out  1  serial line, idle high

Behaviour:
- Register map (word offsets; mem_addr[1:0] ignored):
  - +0 TXDATA: a write pushes mem_wdata[7:0]. Reads return 0.
  - +4 STATUS: read {24'b0, count[3:0], ovf, active, empty, full}, i.e. bit0 full, bit1 empty, bit2 active, bit3 ovf, bits[7:4] count. count is zero-extended to 4 bits; FIFO_DEPTH ≤ 8 fits. Any write clears ovf.
- rdata: 0 when sel is low or mem_addr[2] is 0; otherwise the STATUS word above. Purely combinational, same cycle.
- Push condition: mem_write & sel & ~mem_addr[2].
  - Accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and ovf is set (sticky).
- Write ordering: if a write to STATUS and an overflow occur in the same cycle, set wins. This cannot occur from one store, since each store hits one address.
- FIFO: circular buffer with read/write pointers and a count register.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP. Baud counter runs 0..CLKS_PER_BIT-1; bit counter runs 0..7; an 8-bit shift register holds the byte.
  - IDLE: tx=1. If FIFO is non-empty, pop into the shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit counter 0.
  - DATA: tx=shift[0]. After CLKS_PER_BIT cycles, shift right and increment the bit counter. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- tx is driven from a register; it does not glitch from comb logic.
- active = (state != IDLE).
- Latency: a store at edge k makes count=1 after edge k. Edge k+1 pops the byte and tx falls to 0. The frame lasts exactly 10*CLKS_PER_BIT cycles.
- Reset (asynchronous, also mid-frame) immediately sets:
  - tx=1, state=IDLE, FIFO empty (pointers=0, count=0), ovf=0
  - baud/bit counters=0, shift=0
  - The partial frame is abandoned; a receiver sees a framing error, which is acceptable.
- Writes outside the window (sel=0) have no effect. Reads have no side effects.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=0x400):
- Reset, idle:
  - Stimulus: reset high, then low for 100 cycles.
  - Response: tx=1 throughout. A read of 0x404 returns 0x00000002 (empty).
- Single byte:
  - Stimulus: store 0x000000A5 to 0x400 at edge k.
  - Response: tx low during cycles k+1..k+4. Data bits 1,0,1,0,0,1,0,1 then follow, 4 cycles each. Stop bit is high for 4 cycles. active clears at edge k+41; STATUS then reads 0x02.
- Overflow:
  - Stimulus: 6 back-to-back stores 0x11..0x16 to 0x400.
  - Response: the first store is popped one cycle later, so 5 are accepted (4 remain queued) and 1 is dropped. STATUS reads 0x4D (count=4, ovf, active, full). Line output is 0x11,0x12,0x13,0x14,0x15 with no idle gap between frames.
- ovf clear:
  - Stimulus: after the overflow test, store any value to 0x404.
  - Response: STATUS bit3 reads 0 the next cycle. Queued data is unaffected.
- Address decode:
  - Stimulus: store 0x55 to 0x408 and to 0x3FC.
  - Response: sel=0, FIFO unchanged, tx stays 1. A read at 0x400 returns 0.
- Reset mid-frame:
  - Stimulus: queue 2 bytes, assert reset during bit 3 of the first frame.
  - Response: tx=1 in the same cycle reset rises. After release, STATUS reads 0x02 and no further frames are sent.

Source files
------------

// File: rtl/mmio_uart_tx_if.sv
// Core data-memory port as seen by a memory-mapped peripheral.
// The core drives the store strobe, address and data. The peripheral returns its decode hit and read data.
interface mmio_uart_tx_if;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        sel;
    logic [31:0] rdata;

    modport master (
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  sel,
        input  rdata
    );

    modport slave (
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output sel,
        output rdata
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// TXDATA is at +0 and STATUS is at +4. The line output tx is registered.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_IDLE  | line idle high, waiting for a queued byte
//   S_START | start bit (low) for CLKS_PER_BIT cycles
//   S_DATA  | eight data bits, LSB first
//   S_STOP  | stop bit (high); chains straight into the next frame
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0400
) (
    input  logic          clk,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          ovf;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic fifo_empty, fifo_full, baud_end;
    logic push_req, push_ok, push_drop, status_wr, pop;
    logic [31:0] status_word;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign baud_end   = (baud_cnt == BAUD_LAST);

    assign bus.sel   = (bus.mem_addr[31:3] == BASE_ADDR[31:3]);
    assign push_req  = bus.mem_write & bus.sel & ~bus.mem_addr[2];
    assign status_wr = bus.mem_write & bus.sel &  bus.mem_addr[2];

    // The transmitter pops on leaving IDLE or at the end of a stop bit.
    assign pop       = ~fifo_empty & ((state == S_IDLE) | ((state == S_STOP) & baud_end));
    assign push_ok   = push_req & (~fifo_full | pop);
    assign push_drop = push_req & ~push_ok;

    assign status_word = {24'b0, 4'(count), ovf, (state != S_IDLE), fifo_empty, fifo_full};
    assign bus.rdata   = (bus.sel & bus.mem_addr[2]) ? status_word : 32'b0;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= bus.mem_wdata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push_ok & ~pop)
                count <= count + CW'(1);
            else if (pop & ~push_ok)
                count <= count - CW'(1);
            // A drop in the same cycle as a STATUS write keeps ovf set.
            if (push_drop)
                ovf <= 1'b1;
            else if (status_wr)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        baud_cnt <= '0;
                        state    <= S_START;
                        tx       <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= S_DATA;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= S_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: a line monitor decodes frames against a byte scoreboard.
// Cycle-exact checks cover framing, status, overflow, decode and reset.
module tb_mmio_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tx;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic [7:0] sb [$];
    int         starts [$];

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .BASE_ADDR   (32'h0000_0400)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .tx   (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.mem_write = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
    endtask

    task automatic read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.mem_addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic mon_wait(input int n, inout bit ab);
        repeat (n) begin
            @(negedge clk);
            if (reset) ab = 1'b1;
        end
    endtask

    // Wait until all expected bytes have been seen and the transmitter is idle.
    task automatic wait_drain(input int max_cycles, input string tag);
        bit done;
        done = 1'b0;
        bus.mem_addr = 32'h404;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && bus.rdata[2] == 1'b0) done = 1'b1;
        end
        n_cmp++;
        assert (done) else begin
            n_err++;
            $error("FAIL %s: observed pending=%0d expected drained within %0d cycles", tag, sb.size(), max_cycles);
        end
    endtask

    // Line monitor: samples each bit in its second cycle and compares against the scoreboard.
    initial begin : monitor
        logic [7:0] rx;
        bit         ab;
        int         st;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                st = cyc;
                ab = 1'b0;
                rx = '0;
                mon_wait(CPB + 1, ab);
                for (int i = 0; i < 8; i++) begin
                    if (i > 0) mon_wait(CPB, ab);
                    rx[i] = tx;
                end
                mon_wait(CPB, ab);
                if (!ab) begin
                    check("stop_bit", {31'b0, tx}, 32'h1);
                    starts.push_back(st);
                    n_cmp++;
                    assert (sb.size() > 0) else begin
                        n_err++;
                        $error("FAIL unexpected_frame: observed 0x%02h expected no frame", rx);
                    end
                    if (sb.size() > 0) check("rx_byte", {24'b0, rx}, {24'b0, sb.pop_front()});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] r;
        logic [9:0]  fr;
        bus.mem_write = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", {31'b0, tx}, 32'h1);
        read(32'h404, r);
        check("reset_status", r, 32'h2);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            check("idle_tx", {31'b0, tx}, 32'h1);
        end
        read(32'h404, r);
        check("idle_status", r, 32'h2);

        // Single byte, cycle-exact frame
        sb.push_back(8'hA5);
        store(32'h400, 32'h0000_00A5);
        check("pre_start_tx", {31'b0, tx}, 32'h1);
        bus.mem_addr = 32'h404;
        fr = {1'b1, 8'hA5, 1'b0};
        for (int j = 0; j < FRAME; j++) begin
            @(posedge clk);
            #1;
            check("frame_a5_tx", {31'b0, tx}, {31'b0, fr[j / CPB]});
            if (j == FRAME - 1) check("active_last_cycle", bus.rdata, 32'h6);
        end
        @(posedge clk);
        #1;
        check("active_clear_status", bus.rdata, 32'h2);
        check("after_frame_tx", {31'b0, tx}, 32'h1);
        wait_drain(20, "drain_a5");

        // Overflow: 5 accepted, 1 dropped
        starts.delete();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) sb.push_back(8'(8'h11 + i));
            store(32'h400, 32'(8'h11 + i));
        end
        read(32'h404, r);
        check("ovf_status", r, 32'h4D);
        store(32'h404, 32'hDEAD_BEEF);
        read(32'h404, r);
        check("ovf_clear_status", r, 32'h45);
        wait_drain(5 * FRAME + 50, "drain_ovf");
        check("ovf_frames", 32'(starts.size()), 32'd5);
        for (int i = 1; i < starts.size(); i++)
            check("frame_gap", 32'(starts[i] - starts[i-1]), 32'(FRAME));
        read(32'h404, r);
        check("post_ovf_status", r, 32'h2);

        // Address decode
        @(negedge clk);
        bus.mem_write = 1'b1;
        bus.mem_addr  = 32'h408;
        bus.mem_wdata = 32'h55;
        #1;
        check("sel_408", {31'b0, bus.sel}, 32'h0);
        @(posedge clk);
        #1;
        bus.mem_addr = 32'h3FC;
        #1;
        check("sel_3fc", {31'b0, bus.sel}, 32'h0);
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
        read(32'h404, r);
        check("decode_status", r, 32'h2);
        read(32'h400, r);
        check("txdata_read", r, 32'h0);
        check("sel_400", {31'b0, bus.sel}, 32'h1);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk);
            #1;
            check("decode_tx", {31'b0, tx}, 32'h1);
        end

        // Reset mid-frame during data bit 3 of 0x34 (bit 3 is 0)
        sb.push_back(8'h34);
        sb.push_back(8'hC3);
        store(32'h400, 32'h34);
        store(32'h400, 32'hC3);
        repeat (4 * CPB + 1) @(posedge clk);
        #1;
        check("bit3_tx", {31'b0, tx}, 32'h0);
        reset = 1'b1;
        #1;
        check("async_reset_tx", {31'b0, tx}, 32'h1);
        sb.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        read(32'h404, r);
        check("post_reset_status", r, 32'h2);
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(posedge clk);
            #1;
            check("post_reset_tx", {31'b0, tx}, 32'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
